// File: rtl/axi4_protocol_monitor.sv
// axi4_protocol_monitor: passive AXI4 checker. It watches all five channels
// and reports handshake stability, reserved burst types, burst beat counts,
// orphan responses, READY timeouts and length-FIFO overflow.
// The monitor only has inputs on the bus side and never drives the bus.
// Optional macro AXI4_MON_PERF_CNT_EN builds the burst and stall counters.
// Without the macro those ports are tied to zero.
//
// Handshake rule: a transfer happens on a rising clk edge where VALID and
// READY are both high. Once VALID is high without READY, VALID and the
// payload must hold until the transfer happens.

// Small length FIFO that records burst lengths in issue order.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
// The caller only pops when the FIFO is not empty.
module axi4_mon_len_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && (!full || pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy. The pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end
endmodule

module axi4_protocol_monitor #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 9,
  parameter int LEN_WIDTH  = 4,
  parameter int MAX_OUTST  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      ARESET_n,
  // write address
  input  logic [ID_WIDTH-1:0]       AWID,
  input  logic [ADDR_WIDTH-1:0]     AWADDR,
  input  logic [LEN_WIDTH-1:0]      AWLEN,
  input  logic [2:0]                AWSIZE,
  input  logic [1:0]                AWBURST,
  input  logic                      AWVALID,
  input  logic                      AWREADY,
  // write data
  input  logic [ID_WIDTH-1:0]       WID,
  input  logic [DATA_WIDTH-1:0]     WDATA,
  input  logic [DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                      WLAST,
  input  logic                      WVALID,
  input  logic                      WREADY,
  // write response
  input  logic [ID_WIDTH-1:0]       BID,
  input  logic [1:0]                BRESP,
  input  logic                      BVALID,
  input  logic                      BREADY,
  // read address
  input  logic [ID_WIDTH-1:0]       ARID,
  input  logic [ADDR_WIDTH-1:0]     ARADDR,
  input  logic [LEN_WIDTH-1:0]      ARLEN,
  input  logic [2:0]                ARSIZE,
  input  logic [1:0]                ARBURST,
  input  logic                      ARVALID,
  input  logic                      ARREADY,
  // read data
  input  logic [ID_WIDTH-1:0]       RID,
  input  logic [DATA_WIDTH-1:0]     RDATA,
  input  logic [1:0]                RRESP,
  input  logic                      RLAST,
  input  logic                      RVALID,
  input  logic                      RREADY,
  // error reporting
  input  logic                      err_clr,
  output logic [12:0]               err_pulse,
  output logic [12:0]               err_sticky,
  output logic [4:0]                err_first,
  output logic [$clog2(MAX_OUTST):0] wr_outst,
  output logic [$clog2(MAX_OUTST):0] rd_outst,
  // performance counters
  output logic [31:0]               wr_burst_cnt,
  output logic [31:0]               rd_burst_cnt,
  output logic [31:0]               stall_cnt
);
  localparam int CW    = $clog2(MAX_OUTST) + 1;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int AW_PW = ADDR_WIDTH + LEN_WIDTH + 5;
  localparam int W_PW  = DATA_WIDTH + DATA_WIDTH / 8 + 1;
  localparam int R_PW  = DATA_WIDTH + 3;

  // IDs are outside every check here (ordering is tracked per direction, not per ID).
  logic unused_ids;
  assign unused_ids = ^{AWID, WID, BID, ARID, RID};

  // Channel order in these vectors matches the stability error bits: AW, W, AR, R, B.
  logic [4:0] ch_valid, ch_ready, ch_stall;
  assign ch_valid = {BVALID, RVALID, ARVALID, WVALID, AWVALID};
  assign ch_ready = {BREADY, RREADY, ARREADY, WREADY, AWREADY};
  assign ch_stall = ch_valid & ~ch_ready;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign b_hs  = BVALID && BREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign r_hs  = RVALID && RREADY;

  // ---------------------------------------------------------------- stability
  logic [AW_PW-1:0] aw_pay, aw_pay_q, ar_pay, ar_pay_q;
  logic [W_PW-1:0]  w_pay, w_pay_q;
  logic [R_PW-1:0]  r_pay, r_pay_q;
  logic [1:0]       b_pay_q;
  logic [4:0]       pend_q;
  logic [4:0]       stab_err;

  assign aw_pay = {AWADDR, AWLEN, AWSIZE, AWBURST};
  assign ar_pay = {ARADDR, ARLEN, ARSIZE, ARBURST};
  assign w_pay  = {WDATA, WSTRB, WLAST};
  assign r_pay  = {RDATA, RRESP, RLAST};

  assign stab_err[0] = pend_q[0] && (!AWVALID || (aw_pay != aw_pay_q));
  assign stab_err[1] = pend_q[1] && (!WVALID  || (w_pay  != w_pay_q));
  assign stab_err[2] = pend_q[2] && (!ARVALID || (ar_pay != ar_pay_q));
  assign stab_err[3] = pend_q[3] && (!RVALID  || (r_pay  != r_pay_q));
  assign stab_err[4] = pend_q[4] && (!BVALID  || (BRESP  != b_pay_q));

  // Snapshot of which channels are waiting for READY and what they were offering.
  always_ff @(posedge clk or negedge ARESET_n) begin
    if (!ARESET_n) begin
      pend_q   <= '0;
      aw_pay_q <= '0;
      w_pay_q  <= '0;
      ar_pay_q <= '0;
      r_pay_q  <= '0;
      b_pay_q  <= '0;
    end else begin
      pend_q   <= ch_stall;
      aw_pay_q <= aw_pay;
      w_pay_q  <= w_pay;
      ar_pay_q <= ar_pay;
      r_pay_q  <= r_pay;
      b_pay_q  <= BRESP;
    end
  end

  // ---------------------------------------------------------------- timeout
  logic [TW-1:0] to_cnt [5];
  logic [4:0]    to_hit;

  // A channel times out on its TIMEOUT-th consecutive stalled cycle.
  always_comb begin
    to_hit = '0;
    for (int i = 0; i < 5; i++) begin
      to_hit[i] = ch_stall[i] && (to_cnt[i] == TW'(TIMEOUT - 1));
    end
  end

  // Stall counters saturate at TIMEOUT so a long stall reports only once.
  always_ff @(posedge clk or negedge ARESET_n) begin
    if (!ARESET_n) begin
      for (int i = 0; i < 5; i++) to_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (!ch_stall[i])                    to_cnt[i] <= '0;
        else if (to_cnt[i] != TW'(TIMEOUT))  to_cnt[i] <= to_cnt[i] + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- write tracking
  logic [LEN_WIDTH-1:0] aw_head, w_beat_q;
  logic                 aw_full, aw_empty;
  logic                 w_is_last, aw_pop, w_err, aw_ovf;
  logic                 b_ok, b_err;
  logic [CW-1:0]        b_credit;

  assign w_is_last = (w_beat_q == aw_head);
  assign aw_pop    = w_hs && !aw_empty && w_is_last;
  assign w_err     = w_hs && (aw_empty || (WLAST != w_is_last));
  assign aw_ovf    = aw_hs && aw_full && !aw_pop;
  assign b_ok      = b_hs && (b_credit != '0);
  assign b_err     = b_hs && (b_credit == '0);

  axi4_mon_len_fifo #(.DEPTH(MAX_OUTST), .W(LEN_WIDTH), .CW(CW)) u_aw_fifo (
    .clk   (clk),
    .rst_n (ARESET_n),
    .push  (aw_hs),
    .pop   (aw_pop),
    .din   (AWLEN),
    .head  (aw_head),
    .count (wr_outst),
    .full  (aw_full),
    .empty (aw_empty)
  );

  // W beat counter against the oldest AW, plus credits for responses still owed.
  always_ff @(posedge clk or negedge ARESET_n) begin
    if (!ARESET_n) begin
      w_beat_q <= '0;
      b_credit <= '0;
    end else begin
      if (w_hs && !aw_empty) w_beat_q <= w_is_last ? '0 : w_beat_q + 1'b1;
      if (aw_pop && !b_ok) begin
        if (b_credit != '1) b_credit <= b_credit + 1'b1;
      end else if (!aw_pop && b_ok) begin
        b_credit <= b_credit - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- read tracking
  logic [LEN_WIDTH-1:0] ar_head, r_beat_q;
  logic                 ar_full, ar_empty;
  logic                 r_is_last, ar_pop, r_last_err, r_orphan, ar_ovf;

  assign r_is_last  = (r_beat_q == ar_head);
  assign ar_pop     = r_hs && !ar_empty && r_is_last;
  assign r_last_err = r_hs && !ar_empty && (RLAST != r_is_last);
  assign r_orphan   = r_hs && ar_empty;
  assign ar_ovf     = ar_hs && ar_full && !ar_pop;

  axi4_mon_len_fifo #(.DEPTH(MAX_OUTST), .W(LEN_WIDTH), .CW(CW)) u_ar_fifo (
    .clk   (clk),
    .rst_n (ARESET_n),
    .push  (ar_hs),
    .pop   (ar_pop),
    .din   (ARLEN),
    .head  (ar_head),
    .count (rd_outst),
    .full  (ar_full),
    .empty (ar_empty)
  );

  // R beat counter against the oldest AR; reads complete in order.
  always_ff @(posedge clk or negedge ARESET_n) begin
    if (!ARESET_n) begin
      r_beat_q <= '0;
    end else if (r_hs && !ar_empty) begin
      r_beat_q <= r_is_last ? '0 : r_beat_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------- error reporting
  logic [12:0] err_det;
  logic [3:0]  first_idx;

  // Gather every error seen at this edge into one vector.
  always_comb begin
    err_det       = '0;
    err_det[4:0]  = stab_err;
    err_det[5]    = AWVALID && (AWBURST == 2'b11);
    err_det[6]    = ARVALID && (ARBURST == 2'b11);
    err_det[7]    = w_err;
    err_det[8]    = r_last_err;
    err_det[9]    = b_err;
    err_det[10]   = r_orphan;
    err_det[11]   = |to_hit;
    err_det[12]   = aw_ovf || ar_ovf;
  end

  // Lowest set index wins when several errors land together.
  always_comb begin
    first_idx = '0;
    for (int i = 12; i >= 0; i--) begin
      if (err_det[i]) first_idx = 4'(i);
    end
  end

  // Registered pulse, sticky accumulation and first-error capture; a fresh error beats err_clr.
  always_ff @(posedge clk or negedge ARESET_n) begin
    if (!ARESET_n) begin
      err_pulse  <= '0;
      err_sticky <= '0;
      err_first  <= '0;
    end else begin
      err_pulse  <= err_det;
      err_sticky <= (err_clr ? '0 : err_sticky) | err_det;
      if (err_clr) begin
        err_first <= (err_det != '0) ? {1'b1, first_idx} : 5'd0;
      end else if (!err_first[4] && (err_det != '0)) begin
        err_first <= {1'b1, first_idx};
      end
    end
  end

  // ---------------------------------------------------------------- performance counters
`ifdef AXI4_MON_PERF_CNT_EN
  // Completed bursts per direction and stalled channel-cycles; all wrap at 2^32.
  always_ff @(posedge clk or negedge ARESET_n) begin
    if (!ARESET_n) begin
      wr_burst_cnt <= '0;
      rd_burst_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (aw_pop) wr_burst_cnt <= wr_burst_cnt + 32'd1;
      if (ar_pop) rd_burst_cnt <= rd_burst_cnt + 32'd1;
      stall_cnt <= stall_cnt + 32'(ch_stall[0]) + 32'(ch_stall[1]) + 32'(ch_stall[2])
                             + 32'(ch_stall[3]) + 32'(ch_stall[4]);
    end
  end
`else
  assign wr_burst_cnt = '0;
  assign rd_burst_cnt = '0;
  assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_axi4_protocol_monitor.sv
// Bench for axi4_protocol_monitor: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based reference model.
module tb_axi4_protocol_monitor;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ID_WIDTH   = 9;
  localparam int LEN_WIDTH  = 4;
  localparam int MAX_OUTST  = 4;
  localparam int TIMEOUT    = 16;
  localparam int CW         = $clog2(MAX_OUTST) + 1;
  localparam int CREDIT_MAX = (1 << CW) - 1;

  // ---------------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic ARESET_n = 1'b0;

  logic [ID_WIDTH-1:0]     AWID, WID, BID, ARID, RID;
  logic [ADDR_WIDTH-1:0]   AWADDR, ARADDR;
  logic [LEN_WIDTH-1:0]    AWLEN, ARLEN;
  logic [2:0]              AWSIZE, ARSIZE;
  logic [1:0]              AWBURST, ARBURST, BRESP, RRESP;
  logic                    AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic                    ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [DATA_WIDTH-1:0]   WDATA, RDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    err_clr;
  logic [12:0]             err_pulse, err_sticky;
  logic [4:0]              err_first;
  logic [CW-1:0]           wr_outst, rd_outst;
  logic [31:0]             wr_burst_cnt, rd_burst_cnt, stall_cnt;

  int checks = 0;
  int failures = 0;

  axi4_protocol_monitor #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH),
    .LEN_WIDTH(LEN_WIDTH), .MAX_OUTST(MAX_OUTST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .ARESET_n(ARESET_n),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .err_clr(err_clr), .err_pulse(err_pulse), .err_sticky(err_sticky), .err_first(err_first),
    .wr_outst(wr_outst), .rd_outst(rd_outst),
    .wr_burst_cnt(wr_burst_cnt), .rd_burst_cnt(rd_burst_cnt), .stall_cnt(stall_cnt)
  );

  // ---------------------------------------------------------------- reference model
  int          exp_aw_q[$];
  int          exp_ar_q[$];
  int          w_seen, r_seen, b_credit;
  int          stall_len[5];
  bit          prev_pend[5];
  logic [127:0] prev_pay[5];
  logic [12:0] m_pulse, m_sticky;
  logic [4:0]  m_first;

  task automatic model_reset();
    exp_aw_q.delete();
    exp_ar_q.delete();
    w_seen = 0; r_seen = 0; b_credit = 0;
    for (int i = 0; i < 5; i++) begin
      stall_len[i] = 0; prev_pend[i] = 0; prev_pay[i] = '0;
    end
    m_pulse = '0; m_sticky = '0; m_first = '0;
  endtask

  // Applies the protocol rules to the inputs present at this clock edge.
  task automatic model_sample();
    logic [4:0]   v, r;
    logic [127:0] pay [5];
    logic [12:0]  e;
    int           pre_w, pre_r;
    bit           w_pop, r_pop, last;
    v = {BVALID, RVALID, ARVALID, WVALID, AWVALID};
    r = {BREADY, RREADY, ARREADY, WREADY, AWREADY};
    pay[0] = 128'({AWADDR, AWLEN, AWSIZE, AWBURST});
    pay[1] = 128'({WDATA, WSTRB, WLAST});
    pay[2] = 128'({ARADDR, ARLEN, ARSIZE, ARBURST});
    pay[3] = 128'({RDATA, RRESP, RLAST});
    pay[4] = 128'(BRESP);
    e = '0;
    for (int i = 0; i < 5; i++) begin
      if (prev_pend[i] && (!v[i] || pay[i] != prev_pay[i])) e[i] = 1'b1;
      prev_pend[i] = v[i] && !r[i];
      prev_pay[i]  = pay[i];
      if (v[i] && !r[i]) begin
        stall_len[i]++;
        if (stall_len[i] == TIMEOUT) e[11] = 1'b1;
      end else begin
        stall_len[i] = 0;
      end
    end
    if (AWVALID && AWBURST == 2'b11) e[5] = 1'b1;
    if (ARVALID && ARBURST == 2'b11) e[6] = 1'b1;
    // write side
    pre_w = exp_aw_q.size();
    w_pop = 0;
    if (WVALID && WREADY) begin
      if (pre_w == 0) e[7] = 1'b1;
      else begin
        last = (w_seen == exp_aw_q[0]);
        if (WLAST != last) e[7] = 1'b1;
        if (last) begin
          void'(exp_aw_q.pop_front());
          w_pop = 1; w_seen = 0;
        end else w_seen++;
      end
    end
    if (BVALID && BREADY) begin
      if (b_credit == 0) e[9] = 1'b1;
      else b_credit--;
    end
    if (w_pop && b_credit < CREDIT_MAX) b_credit++;
    if (AWVALID && AWREADY) begin
      if (pre_w == MAX_OUTST && !w_pop) e[12] = 1'b1;
      else exp_aw_q.push_back(int'(AWLEN));
    end
    // read side
    pre_r = exp_ar_q.size();
    r_pop = 0;
    if (RVALID && RREADY) begin
      if (pre_r == 0) e[10] = 1'b1;
      else begin
        last = (r_seen == exp_ar_q[0]);
        if (RLAST != last) e[8] = 1'b1;
        if (last) begin
          void'(exp_ar_q.pop_front());
          r_pop = 1; r_seen = 0;
        end else r_seen++;
      end
    end
    if (ARVALID && ARREADY) begin
      if (pre_r == MAX_OUTST && !r_pop) e[12] = 1'b1;
      else exp_ar_q.push_back(int'(ARLEN));
    end
    // reporting
    if (err_clr) begin
      m_sticky = '0; m_first = '0;
    end
    m_sticky = m_sticky | e;
    if (!m_first[4] && e != '0) begin
      for (int i = 12; i >= 0; i--) if (e[i]) m_first = {1'b1, 4'(i)};
    end
    m_pulse = e;
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic idle_all();
    AWVALID = 0; AWREADY = 0; WVALID = 0; WREADY = 0; WLAST = 0;
    BVALID = 0; BREADY = 0; ARVALID = 0; ARREADY = 0; RVALID = 0; RREADY = 0; RLAST = 0;
    AWBURST = 2'b01; ARBURST = 2'b01; AWSIZE = 3'd2; ARSIZE = 3'd2;
    AWLEN = '0; ARLEN = '0; AWADDR = '0; ARADDR = '0; WDATA = '0; RDATA = '0;
    WSTRB = '1; BRESP = '0; RRESP = '0;
    AWID = '0; WID = '0; BID = '0; ARID = '0; RID = '0;
    err_clr = 0;
  endtask

  // One clock: the model sees the same edge as the DUT; returns 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (ARESET_n) model_sample();
    #1;
  endtask

  task automatic do_reset();
    idle_all();
    ARESET_n = 0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    ARESET_n = 1;
  endtask

  task automatic drive_aw(input logic [LEN_WIDTH-1:0] len, input logic [ADDR_WIDTH-1:0] addr);
    AWVALID = 1; AWREADY = 1; AWLEN = len; AWADDR = addr; AWBURST = 2'b01;
  endtask

  task automatic drive_w(input logic last);
    WVALID = 1; WREADY = 1; WLAST = last; WDATA = $urandom;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    do_reset();
    checks++;
    if (err_pulse !== 13'h0) begin failures++; $display("FAIL reset_pulse got=%h exp=0", err_pulse); end
    checks++;
    if (err_sticky !== 13'h0) begin failures++; $display("FAIL reset_sticky got=%h exp=0", err_sticky); end
    checks++;
    if (err_first !== 5'h0) begin failures++; $display("FAIL reset_first got=%h exp=0", err_first); end
    checks++;
    if (wr_outst !== '0 || rd_outst !== '0) begin
      failures++; $display("FAIL reset_outst got=%0d/%0d exp=0/0", wr_outst, rd_outst);
    end
    checks++;
    if ({wr_burst_cnt, rd_burst_cnt, stall_cnt} !== 96'h0) begin
      failures++; $display("FAIL reset_perf got=%h/%h/%h exp=0", wr_burst_cnt, rd_burst_cnt, stall_cnt);
    end
  endtask

  task automatic test_legal_write_read();
    do_reset();
    drive_aw(4'd3, 32'h100);
    step();
    checks++;
    if (wr_outst !== CW'(1)) begin failures++; $display("FAIL wr_outst_after_aw got=%0d exp=1", wr_outst); end
    AWVALID = 0; AWREADY = 0;
    for (int b = 0; b < 4; b++) begin
      drive_w(b == 3);
      step();
    end
    checks++;
    if (wr_outst !== CW'(0)) begin failures++; $display("FAIL wr_outst_after_wlast got=%0d exp=0", wr_outst); end
    WVALID = 0; WREADY = 0; WLAST = 0;
    BVALID = 1; BREADY = 1;
    step();
    BVALID = 0; BREADY = 0;
    ARVALID = 1; ARREADY = 1; ARLEN = 4'd2; ARADDR = 32'h200;
    step();
    checks++;
    if (rd_outst !== CW'(1)) begin failures++; $display("FAIL rd_outst_after_ar got=%0d exp=1", rd_outst); end
    ARVALID = 0; ARREADY = 0;
    for (int b = 0; b < 3; b++) begin
      RVALID = 1; RREADY = 1; RLAST = (b == 2); RDATA = $urandom;
      step();
    end
    RVALID = 0; RREADY = 0; RLAST = 0;
    step();
    checks++;
    if (rd_outst !== CW'(0)) begin failures++; $display("FAIL rd_outst_after_rlast got=%0d exp=0", rd_outst); end
    checks++;
    if (err_sticky !== 13'h0) begin failures++; $display("FAIL legal_sticky got=%h exp=0", err_sticky); end
    // R beat with no AR outstanding
    RVALID = 1; RREADY = 1; RLAST = 1;
    step();
    checks++;
    if (err_pulse !== 13'h400) begin failures++; $display("FAIL r_orphan got=%h exp=400", err_pulse); end
    idle_all();
    step();
  endtask

  task automatic test_wlast_early();
    do_reset();
    drive_aw(4'd3, 32'h300);
    step();
    AWVALID = 0; AWREADY = 0;
    drive_w(1'b0);
    step();
    checks++;
    if (err_pulse !== 13'h0) begin failures++; $display("FAIL wlast_beat1 got=%h exp=0", err_pulse); end
    drive_w(1'b1);
    step();
    checks++;
    if (err_pulse !== 13'h080) begin failures++; $display("FAIL wlast_early_pulse got=%h exp=080", err_pulse); end
    WVALID = 0; WREADY = 0; WLAST = 0;
    step();
    checks++;
    if (err_pulse !== 13'h0) begin failures++; $display("FAIL wlast_pulse_width got=%h exp=0", err_pulse); end
    checks++;
    if (err_first !== 5'h17) begin failures++; $display("FAIL wlast_first got=%h exp=17", err_first); end
    checks++;
    if (wr_outst !== CW'(1)) begin failures++; $display("FAIL wlast_outst got=%0d exp=1", wr_outst); end
  endtask

  task automatic test_timeout();
    int n_to, at_k, n_stab;
    do_reset();
    n_to = 0; at_k = -1; n_stab = 0;
    ARVALID = 1; ARREADY = 0; ARADDR = 32'h1000; ARLEN = 4'd0;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (err_pulse[11]) begin n_to++; at_k = k; end
      if (err_pulse[2]) n_stab++;
    end
    checks++;
    if (n_to !== 1) begin failures++; $display("FAIL timeout_count got=%0d exp=1", n_to); end
    checks++;
    if (at_k !== TIMEOUT) begin failures++; $display("FAIL timeout_cycle got=%0d exp=%0d", at_k, TIMEOUT); end
    checks++;
    if (n_stab !== 0) begin failures++; $display("FAIL timeout_stable_stall got=%0d exp=0", n_stab); end
    ARADDR = 32'h2000;
    step();
    checks++;
    if (err_pulse !== 13'h004) begin failures++; $display("FAIL ar_stability got=%h exp=004", err_pulse); end
    ARREADY = 1;
    step();
    idle_all();
    step();
  endtask

  task automatic test_orphan_b();
    do_reset();
    BVALID = 1; BREADY = 1;
    step();
    checks++;
    if (err_pulse !== 13'h200) begin failures++; $display("FAIL b_orphan got=%h exp=200", err_pulse); end
    checks++;
    if (err_first !== 5'h19) begin failures++; $display("FAIL b_orphan_first got=%h exp=19", err_first); end
    BVALID = 0; BREADY = 0; err_clr = 1;
    step();
    checks++;
    if (err_sticky !== 13'h0 || err_first !== 5'h0) begin
      failures++; $display("FAIL err_clr got=%h/%h exp=0/0", err_sticky, err_first);
    end
    BVALID = 1; BREADY = 1;
    step();
    checks++;
    if (err_sticky !== 13'h200 || err_first !== 5'h19) begin
      failures++; $display("FAIL clr_vs_new got=%h/%h exp=200/19", err_sticky, err_first);
    end
    idle_all();
    step();
  endtask

  task automatic test_overflow();
    do_reset();
    drive_aw(4'd0, 32'h400);
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (err_pulse[12] !== (k == 5)) begin
        failures++; $display("FAIL ovf_pulse k=%0d got=%b exp=%b", k, err_pulse[12], (k == 5));
      end
      checks++;
      if (wr_outst !== CW'((k < 4) ? k : 4)) begin
        failures++; $display("FAIL ovf_outst k=%0d got=%0d exp=%0d", k, wr_outst, (k < 4) ? k : 4);
      end
    end
    // push and pop together on a full FIFO is legal
    drive_w(1'b1);
    step();
    checks++;
    if (err_pulse !== 13'h0 || wr_outst !== CW'(4)) begin
      failures++; $display("FAIL full_push_pop got=%h/%0d exp=0/4", err_pulse, wr_outst);
    end
    idle_all();
    step();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    drive_aw(4'd1, 32'h500);
    step();
    step();
    AWVALID = 0; AWREADY = 0;
    drive_w(1'b0);
    step();
    checks++;
    if (wr_outst !== CW'(2)) begin failures++; $display("FAIL mid_outst got=%0d exp=2", wr_outst); end
    ARESET_n = 0;
    #1;
    checks++;
    if ({err_pulse, err_sticky, err_first, wr_outst, rd_outst} !== '0) begin
      failures++; $display("FAIL mid_reset_outputs got=%h/%h/%h/%0d/%0d exp=0",
                           err_pulse, err_sticky, err_first, wr_outst, rd_outst);
    end
    do_reset();
    drive_aw(4'd1, 32'h600);
    step();
    AWVALID = 0; AWREADY = 0;
    drive_w(1'b0);
    step();
    drive_w(1'b1);
    step();
    WVALID = 0; WREADY = 0; WLAST = 0;
    BVALID = 1; BREADY = 1;
    step();
    idle_all();
    step();
    checks++;
    if (err_sticky !== 13'h0 || wr_outst !== CW'(0)) begin
      failures++; $display("FAIL post_reset_burst got=%h/%0d exp=0/0", err_sticky, wr_outst);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!(AWVALID && !AWREADY && $urandom_range(0, 9) != 0)) begin
        AWVALID = ($urandom_range(0, 2) == 0);
        AWADDR = $urandom; AWLEN = 4'($urandom_range(0, 3)); AWSIZE = 3'd2;
        AWBURST = ($urandom_range(0, 29) == 0) ? 2'b11 : 2'b01; AWID = 9'($urandom);
      end
      AWREADY = ($urandom_range(0, 2) != 0);
      if (!(WVALID && !WREADY && $urandom_range(0, 9) != 0)) begin
        WVALID = (exp_aw_q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
        WDATA = $urandom; WSTRB = 4'($urandom);
        WLAST = ($urandom_range(0, 9) != 0) ? (exp_aw_q.size() > 0 && w_seen == exp_aw_q[0])
                                            : 1'($urandom);
      end
      WREADY = ($urandom_range(0, 2) != 0);
      if (!(BVALID && !BREADY && $urandom_range(0, 9) != 0)) begin
        BVALID = (b_credit > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
        BRESP = 2'($urandom);
      end
      BREADY = ($urandom_range(0, 2) != 0);
      if (!(ARVALID && !ARREADY && $urandom_range(0, 9) != 0)) begin
        ARVALID = ($urandom_range(0, 2) == 0);
        ARADDR = $urandom; ARLEN = 4'($urandom_range(0, 3)); ARSIZE = 3'd2;
        ARBURST = ($urandom_range(0, 29) == 0) ? 2'b11 : 2'b01;
      end
      ARREADY = ($urandom_range(0, 2) != 0);
      if (!(RVALID && !RREADY && $urandom_range(0, 9) != 0)) begin
        RVALID = (exp_ar_q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
        RDATA = $urandom; RRESP = 2'($urandom);
        RLAST = ($urandom_range(0, 9) != 0) ? (exp_ar_q.size() > 0 && r_seen == exp_ar_q[0])
                                            : 1'($urandom);
      end
      RREADY = ($urandom_range(0, 2) != 0);
      err_clr = ($urandom_range(0, 49) == 0);
      step();
      checks++;
      if (err_pulse !== m_pulse) begin
        failures++; $display("FAIL rand_pulse cyc=%0d got=%h exp=%h", cyc, err_pulse, m_pulse);
      end
      checks++;
      if (err_sticky !== m_sticky) begin
        failures++; $display("FAIL rand_sticky cyc=%0d got=%h exp=%h", cyc, err_sticky, m_sticky);
      end
      checks++;
      if (err_first !== m_first) begin
        failures++; $display("FAIL rand_first cyc=%0d got=%h exp=%h", cyc, err_first, m_first);
      end
      checks++;
      if (wr_outst !== CW'(exp_aw_q.size())) begin
        failures++; $display("FAIL rand_wr_outst cyc=%0d got=%0d exp=%0d", cyc, wr_outst, exp_aw_q.size());
      end
      checks++;
      if (rd_outst !== CW'(exp_ar_q.size())) begin
        failures++; $display("FAIL rand_rd_outst cyc=%0d got=%0d exp=%0d", cyc, rd_outst, exp_ar_q.size());
      end
    end
    idle_all();
    step();
  endtask

  // ---------------------------------------------------------------- sequence and report
  initial begin
    idle_all();
    model_reset();
    test_reset();
    test_legal_write_read();
    test_wlast_early();
    test_timeout();
    test_orphan_b();
    test_overflow();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi4_protocol_monitor.md
Name: axi4_protocol_monitor

Overview:
- Synthesizable, passive AXI4 protocol checker that snoops all five channels and is instanced alongside the master/slave agents.
- It generalises the per-channel interface assertions:
  - parametrised widths, timeout and outstanding depth;
  - burst beat-count tracking against AWLEN/ARLEN;
  - orphan-response detection;
  - sticky error reporting readable by the environment and by hardware.
- Never drives the bus.

Parameters:
- ADDR_WIDTH, 32, address width of AWADDR/ARADDR.
- DATA_WIDTH, 32, data width; WSTRB is DATA_WIDTH/8.
- ID_WIDTH, 9, width of all ID fields.
- LEN_WIDTH, 4, width of AWLEN/ARLEN; burst length is LEN+1.
- MAX_OUTST, 4, depth of the AW and AR length FIFOs; must be a power of 2, ≥2.
- TIMEOUT, 16, maximum stall cycles (VALID high, READY low) before a timeout error.

Ports:
- clk  input  1  bus clock; all logic on posedge.
- ARESET_n  input  1  reset, asynchronous, active-low.
- AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, AWREADY  input  ID_WIDTH/ADDR_WIDTH/LEN_WIDTH/3/2/1/1  write address channel.
- WID, WDATA, WSTRB, WLAST, WVALID, WREADY  input  ID_WIDTH/DATA_WIDTH/DATA_WIDTH/8/1/1/1  write data channel.
- BID, BRESP, BVALID, BREADY  input  ID_WIDTH/2/1/1  write response channel.
- ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, ARREADY  input  as AW  read address channel.
- RID, RDATA, RRESP, RLAST, RVALID, RREADY  input  ID_WIDTH/DATA_WIDTH/2/1/1/1  read data channel.
- err_clr  input  1  synchronous clear of err_sticky and err_first.
- err_pulse  output  13  one-cycle flag per error detected.
- err_sticky  output  13  accumulated errors since reset/clear.
- err_first  output  5  bit4 = valid, bits3:0 = index of first error after reset/clear.
- wr_outst  output  $clog2(MAX_OUTST)+1  AW entries awaiting WLAST.
- rd_outst  output  $clog2(MAX_OUTST)+1  AR entries awaiting RLAST.

Behaviour:
- Reset: all outputs 0; FIFOs, beat counters, stall counters and the B-credit counter cleared. Asserting reset mid-burst discards all tracking state.
- Error index map:
  - 0 AW, 1 W, 2 AR, 3 R, 4 B stability;
  - 5 AWBURST==2'b11, 6 ARBURST==2'b11 (checked while VALID);
  - 7 WLAST mismatch, 8 RLAST mismatch;
  - 9 B without completed write, 10 R without pending read;
  - 11 READY timeout on any channel;
  - 12 AW/AR issued with FIFO full.
- Latency: every check samples at posedge N; err_pulse asserts in cycle N+1 and lasts one cycle.
- Stability check:
  - Register a pending flag (VALID && !READY) and the channel payload each cycle.
  - If pending was set at N-1 and, at N, VALID is low or any payload field differs, flag the channel error.
  - Payload excludes ID and VALID.
- Timeout:
  - Per-channel counter increments while VALID && !READY; it clears on handshake or when VALID is low.
  - Bit 11 pulses once, when the counter reaches TIMEOUT; it does not re-pulse until the stall ends.
- Write tracking:
  - AW handshake pushes AWLEN into the AW FIFO.
  - The W beat counter counts W handshakes against the FIFO head.
  - WLAST asserted with counter != head, or deasserted with counter == head → bit 7.
  - The head pops on the beat where counter == head, regardless of WLAST; the B-credit counter increments.
  - A W handshake with the AW FIFO empty → bit 7 (W must follow its AW).
  - A B handshake with B-credit 0 → bit 9; otherwise B-credit decrements.
- Read tracking:
  - Same structure for AR/R with bits 8 and 10, in-order (no interleave).
- Simultaneous events:
  - Push and pop in the same cycle on a full FIFO is legal; occupancy is unchanged.
  - AW pop via last W beat and B-credit consume in the same cycle net to zero.
- Overflow: a push into a full FIFO with no simultaneous pop → bit 12; the entry is dropped.
- Error reporting:
  - err_sticky |= err_pulse each cycle; err_clr clears it, but a new pulse in the same cycle wins.
  - err_first latches the lowest set index of the first nonzero err_pulse.
  - err_first holds until err_clr.
- Counter widths: beat counters are LEN_WIDTH; B-credit is $clog2(MAX_OUTST)+1 and saturates (no wrap).

Optional Feature:
- AXI4_MON_PERF_CNT_EN: adds these ports:
  - wr_burst_cnt (32) and rd_burst_cnt (32): completed bursts;
  - stall_cnt (32): total READY-low cycles with VALID high, across all channels.
- All three counters wrap at 2^32 and clear on reset.
- Without the macro, the ports remain and are tied to 0, so no counter logic is built.

Test Plan:
- AW with AWLEN=3, then 4 W beats with WLAST on beat 4, then B → err_sticky=0, wr_outst 1→0.
- AWLEN=3, WLAST on beat 2 → err_pulse[7] for exactly one cycle after beat 2; err_first=5'h17.
- ARVALID held with ARREADY low for 17 cycles → single err_pulse[11] at cycle TIMEOUT+1; ARADDR changed mid-stall → err_pulse[2].
- BVALID/BREADY handshake with no prior write → err_pulse[9]; then err_clr → err_sticky=0, err_first=0.
- 5 AW handshakes with no W (MAX_OUTST=4) → err_pulse[12] on the 5th; wr_outst stays 4.
- Reset asserted with wr_outst=2 mid-burst, then released → all outputs 0; a subsequent legal burst completes error-free.
